// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan driver: the active-low
// segment type, the blank pattern and the hex-to-segment table.
package seven_seg_pkg;

  localparam int MAX_DIGITS = 8;

  // Active-low segment vector ordered {g,f,e,d,c,b,a}.
  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h7F;

  localparam seg7_t HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seven_seg_hex_lut.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seven_seg_hex_lut
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output seg7_t      o_seg
);

  assign o_seg = HEX_SEG[i_nibble];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment scan driver with dead-time
// blanking and frame-synchronous loads. Optional SEVEN_SEG_LEADING_ZERO_BLANK_EN
// auto-blanks leading zero digits when the active registers are written.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DEADTIME    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  generate
    if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_num_digits
      $error("seven_seg_scan_driver: NUM_DIGITS must be in 1..%0d", MAX_DIGITS);
    end
    if (REFRESH_DIV <= DEADTIME) begin : g_bad_refresh_div
      $error("seven_seg_scan_driver: REFRESH_DIV must exceed DEADTIME");
    end
  endgenerate

  // Scan position
  logic [CNT_W-1:0]        r_div_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic                    w_slot_end;
  logic                    w_last_idx;
  logic                    w_frame_end;
  logic                    w_dead;

  // Shadow (pending) and displayed (active) content
  logic [4*NUM_DIGITS-1:0] r_pend_digits;
  logic [NUM_DIGITS-1:0]   r_pend_blank;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic                    r_pend_valid;
  logic [4*NUM_DIGITS-1:0] r_act_digits;
  logic [NUM_DIGITS-1:0]   r_act_blank;
  logic [NUM_DIGITS-1:0]   r_act_dp;

  logic                    w_bypass;
  logic                    w_commit;
  logic [4*NUM_DIGITS-1:0] w_src_digits;
  logic [NUM_DIGITS-1:0]   w_src_blank;
  logic [NUM_DIGITS-1:0]   w_src_dp;
  logic [NUM_DIGITS-1:0]   w_auto_blank;

  // Per-slot selection
  logic [3:0]              w_nibble;
  logic                    w_blank;
  logic                    w_dp;
  logic [NUM_DIGITS-1:0]   w_an_sel;
  seg7_t                   w_seg;

  // Output registers
  seg7_t                   r_seg_n;
  logic                    r_dp_n;
  logic [NUM_DIGITS-1:0]   r_an_n;
  logic                    r_frame_done;

  assign w_slot_end  = (r_div_cnt == CNT_W'(REFRESH_DIV - 1));
  assign w_last_idx  = (r_idx == IDX_W'(NUM_DIGITS - 1));
  assign w_frame_end = w_slot_end && w_last_idx;
  assign w_dead      = (r_div_cnt < CNT_W'(DEADTIME));

  always_ff @(posedge clk) begin
    // NOTE: all state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_idx     <= '0;
    end else if (w_slot_end) begin
      r_div_cnt <= '0;
      r_idx     <= w_last_idx ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_div_cnt <= r_div_cnt + CNT_W'(1);
    end
  end

  // A load landing on the frame boundary skips the shadow and goes live at once.
  assign w_bypass     = load && w_frame_end;
  assign w_commit     = w_frame_end && (load || r_pend_valid);
  assign w_src_digits = w_bypass ? digits_in : r_pend_digits;
  assign w_src_blank  = w_bypass ? blank_in  : r_pend_blank;
  assign w_src_dp     = w_bypass ? dp_in     : r_pend_dp;

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  always_comb begin
    logic v_zero_run;
    w_auto_blank = '0;
    v_zero_run   = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      v_zero_run      = v_zero_run && (w_src_digits[4*k +: 4] == 4'h0);
      w_auto_blank[k] = v_zero_run;
    end
  end
`else
  assign w_auto_blank = '0;
`endif

  always_ff @(posedge clk) begin
    // NOTE: shadow and active content are reset so a mid-frame reset never
    // leaves stale digits on the display.
    if (!rst_n) begin
      r_pend_digits <= '0;
      r_pend_blank  <= '0;
      r_pend_dp     <= '0;
      r_pend_valid  <= 1'b0;
      r_act_digits  <= '0;
      r_act_blank   <= '0;
      r_act_dp      <= '0;
    end else begin
      if (load) begin
        r_pend_digits <= digits_in;
        r_pend_blank  <= blank_in;
        r_pend_dp     <= dp_in;
      end
      r_pend_valid <= w_frame_end ? 1'b0 : (r_pend_valid | load);
      if (w_commit) begin
        r_act_digits <= w_src_digits;
        r_act_blank  <= w_src_blank | w_auto_blank;
        r_act_dp     <= w_src_dp;
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // infer a latch when no digit index matches.
    w_nibble = 4'h0;
    w_blank  = 1'b1;
    w_dp     = 1'b0;
    w_an_sel = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_nibble    = r_act_digits[4*k +: 4];
        w_blank     = r_act_blank[k];
        w_dp        = r_act_dp[k];
        w_an_sel[k] = 1'b0;
      end
    end
  end

  seven_seg_hex_lut u_hex_lut (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seg_n      <= SEG_BLANK;
      r_dp_n       <= 1'b1;
      r_an_n       <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      if (w_dead) begin
        r_an_n  <= '1;
        r_seg_n <= SEG_BLANK;
        r_dp_n  <= 1'b1;
      end else begin
        r_an_n  <= w_an_sel;
        r_seg_n <= w_blank ? SEG_BLANK : w_seg;
        r_dp_n  <= w_blank | ~w_dp;
      end
    end
  end

  assign seg_n      = r_seg_n;
  assign dp_n       = r_dp_n;
  assign an_n       = r_an_n;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench for seven_seg_scan_driver (4 digits, 4-cycle slots, 1 dead cycle).
module tb_seven_seg_scan_driver;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int DT = 1;
  localparam int FRAME = ND * RD;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  localparam bit LZ_EN = 1'b1;
`else
  localparam bit LZ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  blank_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_done;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .DEADTIME    (DT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .digits_in  (digits_in),
    .blank_in   (blank_in),
    .dp_in      (dp_in),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    string      tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_cyc    = 0;

  // Display-level model: what is on show this frame, and what is queued.
  logic [15:0] m_dig, p_dig;
  logic [3:0]  m_blk, m_dp, p_blk, p_dp;
  bit          p_v;

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'h0: ref_seg = 7'h40;  4'h1: ref_seg = 7'h79;
      4'h2: ref_seg = 7'h24;  4'h3: ref_seg = 7'h30;
      4'h4: ref_seg = 7'h19;  4'h5: ref_seg = 7'h12;
      4'h6: ref_seg = 7'h02;  4'h7: ref_seg = 7'h78;
      4'h8: ref_seg = 7'h00;  4'h9: ref_seg = 7'h10;
      4'hA: ref_seg = 7'h08;  4'hB: ref_seg = 7'h03;
      4'hC: ref_seg = 7'h46;  4'hD: ref_seg = 7'h21;
      4'hE: ref_seg = 7'h06;  default: ref_seg = 7'h0E;
    endcase
  endfunction

  function automatic logic [3:0] lz_mask(input logic [15:0] d);
    lz_mask = '0;
    for (int k = 1; k < ND; k++)
      lz_mask[k] = LZ_EN && ((d >> (4 * k)) == 16'h0);
  endfunction

  task automatic check_out();
    exp_t        e;
    logic [12:0] obs, req;
    e   = sb_q.pop_front();
    obs = {an_n, seg_n, dp_n, frame_done};
    req = {e.an, e.seg, e.dp, e.fd};
    n_checks++;
    assert (obs === req) n_pass++;
    else $error("FAIL %s: observed an_n=%h seg_n=%h dp_n=%b frame_done=%b, expected an_n=%h seg_n=%h dp_n=%b frame_done=%b",
                e.tag, an_n, seg_n, dp_n, frame_done, e.an, e.seg, e.dp, e.fd);
  endtask

  task automatic cycle(input bit ld, input logic [15:0] d, input logic [3:0] b,
                       input logic [3:0] p, input string tag);
    exp_t e;
    int   slot, ph;
    load      = ld;
    digits_in = d;
    blank_in  = b;
    dp_in     = p;
    if (n_cyc % FRAME == 0 && p_v) begin
      m_dig = p_dig;
      m_blk = p_blk | lz_mask(p_dig);
      m_dp  = p_dp;
      p_v   = 1'b0;
    end
    slot  = (n_cyc / RD) % ND;
    ph    = n_cyc % RD;
    e.tag = $sformatf("%s@%0d", tag, n_cyc);
    e.fd  = (n_cyc % FRAME == FRAME - 1);
    if (ph < DT) begin
      e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
    end else begin
      e.an = ~(4'b0001 << slot);
      if (m_blk[slot]) begin
        e.seg = 7'h7F; e.dp = 1'b1;
      end else begin
        e.seg = ref_seg(m_dig[4*slot +: 4]);
        e.dp  = ~m_dp[slot];
      end
    end
    if (ld) begin
      p_dig = d; p_blk = b; p_dp = p; p_v = 1'b1;
    end
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    check_out();
    load = 1'b0;
    n_cyc++;
  endtask

  task automatic run(input int k, input string tag);
    repeat (k) cycle(1'b0, 16'h0, 4'h0, 4'h0, tag);
  endtask

  task automatic do_reset(input string tag);
    exp_t e;
    rst_n = 1'b0;
    load  = 1'b0;
    e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.fd = 1'b0; e.tag = tag;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    check_out();
    rst_n = 1'b1;
    m_dig = '0; m_blk = '0; m_dp = '0;
    p_dig = '0; p_blk = '0; p_dp = '0; p_v = 1'b0;
    n_cyc = 0;
  endtask

  initial begin
    rst_n     = 1'b0;
    load      = 1'b0;
    digits_in = '0;
    blank_in  = '0;
    dp_in     = '0;
    @(negedge clk);
    do_reset("reset0");
    do_reset("reset1");

    // Free-run scan of zeros across two frames.
    run(32, "idle");

    // Mid-frame load: current frame keeps 0000, next shows 3A7F with dp on digit 1.
    run(5, "pre_mid");
    cycle(1'b1, 16'h3A7F, 4'b0000, 4'b0010, "load_mid");
    run(26, "mid_frames");

    // Two loads in one frame: last one wins.
    run(2, "pre_two");
    cycle(1'b1, 16'h1111, 4'b0000, 4'b0000, "load_1111");
    run(3, "between");
    cycle(1'b1, 16'h2222, 4'b0000, 4'b0000, "load_2222");
    run(25, "two_loads");

    // Load coincident with the frame boundary.
    run(15, "pre_boundary");
    cycle(1'b1, 16'h0005, 4'b0000, 4'b0000, "load_boundary");
    n_checks++;
    assert (dut.r_pend_valid === 1'b0) n_pass++;
    else $error("FAIL pend_valid_clear: observed %b expected 0", dut.r_pend_valid);
    run(16, "bypass_frame");

    // Blanked digit 3 with its decimal point requested.
    run(2, "pre_blank");
    cycle(1'b1, 16'h8765, 4'b1000, 4'b1000, "load_blank");
    run(29, "blank_frames");

    // Reset during slot 2 of an all-F frame.
    run(2, "pre_ffff");
    cycle(1'b1, 16'hFFFF, 4'b0000, 4'b0000, "load_ffff");
    run(22, "ffff_frame");
    do_reset("mid_reset");
    run(8, "after_reset");

    // Leading zeros (auto-blanked only when the feature is built in).
    cycle(1'b1, 16'h0050, 4'b0000, 4'b0000, "load_0050");
    run(23, "lzb_frame");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
